// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment and LED bank scanners.
package seg_pkg;

   localparam int unsigned SEG_NIBBLE_W        = 4;
   localparam int unsigned SEG_CLK_DIV_DEFAULT = 250000;

   // Circular upward search from cur+1 over n positions; returns 0 for an empty mask.
   function automatic logic [3:0] next_valid_idx(input logic [15:0] mask,
                                                 input logic [3:0]  cur,
                                                 input int unsigned n);
      logic [3:0] res;
      logic       found;
      logic [4:0] idx;
      res   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= 16; k++) begin
         idx = 5'(cur) + 5'(k);
         if (idx >= 5'(n)) begin
            idx = idx - 5'(n);
         end
         if (!found && (k <= n) && mask[idx[3:0]]) begin
            res   = idx[3:0];
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Slot prescaler: slot_tick on the last cycle of each slot, plus the PWM sub-slot index.
module seg_tick_div #(
   parameter int unsigned CLK_DIV  = 16,
   parameter int unsigned BRIGHT_W = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   output logic                slot_tick_o,
   output logic [BRIGHT_W-1:0] sub_o
);

   localparam int unsigned CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SUB_SHIFT = $clog2(CLK_DIV >> BRIGHT_W);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign slot_tick_o = (cnt_q == CNT_W'(CLK_DIV - 1));
   assign cnt_d       = slot_tick_o ? '0 : cnt_q + CNT_W'(1);
   assign sub_o       = BRIGHT_W'(cnt_q >> SUB_SHIFT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with frame-synchronous commit, digit skipping
// and PWM brightness.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned CLK_DIV    = SEG_CLK_DIV_DEFAULT,
   parameter int unsigned BRIGHT_W   = 3,
   localparam int unsigned IDX_W     = $clog2(NUM_DIGITS)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0] digit_data_i,
   input  logic [NUM_DIGITS-1:0]            digit_valid_i,
   input  logic [NUM_DIGITS-1:0]            digit_dp_i,
   input  logic                             load_i,
   input  logic [BRIGHT_W-1:0]              brightness_i,
   output logic [SEG_NIBBLE_W-1:0]          seg_data_o,
   output logic                             seg_dp_o,
   output logic [IDX_W-1:0]                 seg_an_o,
   output logic                             seg_en_o,
   output logic                             frame_done_o
);

   localparam int unsigned DATA_W = SEG_NIBBLE_W * NUM_DIGITS;

   logic                slot_tick;
   logic [BRIGHT_W-1:0] sub;

   seg_tick_div #(
      .CLK_DIV  (CLK_DIV),
      .BRIGHT_W (BRIGHT_W)
   ) u_tick_div (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .slot_tick_o (slot_tick),
      .sub_o       (sub)
   );

   logic [DATA_W-1:0]       pend_data_q, pend_data_d, com_data_q, com_data_d;
   logic [NUM_DIGITS-1:0]   pend_valid_q, pend_valid_d, com_valid_q, com_valid_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, com_dp_q, com_dp_d;
   logic [IDX_W-1:0]        cur_idx_q, cur_idx_d, step_idx;
   logic [BRIGHT_W-1:0]     bright_q, bright_d;
   logic                    frame_done_q, frame_done_d;
   logic                    commit;
   logic [SEG_NIBBLE_W-1:0] seg_data_q, seg_data_d;
   logic                    seg_dp_q, seg_dp_d;
   logic [IDX_W-1:0]        seg_an_q, seg_an_d;
   logic                    seg_en_q, seg_en_d;

   always_comb begin
      pend_data_d  = pend_data_q;
      pend_valid_d = pend_valid_q;
      pend_dp_d    = pend_dp_q;
      com_data_d   = com_data_q;
      com_valid_d  = com_valid_q;
      com_dp_d     = com_dp_q;
      cur_idx_d    = cur_idx_q;
      bright_d     = bright_q;
      frame_done_d = 1'b0;
      commit       = 1'b0;
      step_idx     = IDX_W'(next_valid_idx(16'(com_valid_q), 4'(cur_idx_q), NUM_DIGITS));

      if (load_i) begin
         pend_data_d  = digit_data_i;
         pend_valid_d = digit_valid_i;
         pend_dp_d    = digit_dp_i;
      end

      if (slot_tick) begin
         bright_d = brightness_i;
         // An empty display commits every slot so the first load shows up quickly.
         if (com_valid_q == '0) begin
            commit = 1'b1;
         end else if (step_idx <= cur_idx_q) begin
            commit       = 1'b1;
            frame_done_d = 1'b1;
         end else begin
            cur_idx_d = step_idx;
         end
         if (commit) begin
            com_data_d  = pend_data_q;
            com_valid_d = pend_valid_q;
            com_dp_d    = pend_dp_q;
            cur_idx_d   = IDX_W'(next_valid_idx(16'(pend_valid_q), 4'(cur_idx_q), NUM_DIGITS));
         end
      end
   end

   always_comb begin
      seg_an_d   = cur_idx_q;
      seg_data_d = com_data_q[SEG_NIBBLE_W*cur_idx_q +: SEG_NIBBLE_W];
      seg_dp_d   = com_dp_q[cur_idx_q];
      seg_en_d   = (com_valid_q != '0) && (sub <= bright_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_data_q  <= '0;
         pend_valid_q <= '0;
         pend_dp_q    <= '0;
         com_data_q   <= '0;
         com_valid_q  <= '0;
         com_dp_q     <= '0;
         cur_idx_q    <= '0;
         bright_q     <= '0;
         frame_done_q <= 1'b0;
         seg_data_q   <= '0;
         seg_dp_q     <= 1'b0;
         seg_an_q     <= '0;
         seg_en_q     <= 1'b0;
      end else begin
         pend_data_q  <= pend_data_d;
         pend_valid_q <= pend_valid_d;
         pend_dp_q    <= pend_dp_d;
         com_data_q   <= com_data_d;
         com_valid_q  <= com_valid_d;
         com_dp_q     <= com_dp_d;
         cur_idx_q    <= cur_idx_d;
         bright_q     <= bright_d;
         frame_done_q <= frame_done_d;
         seg_data_q   <= seg_data_d;
         seg_dp_q     <= seg_dp_d;
         seg_an_q     <= seg_an_d;
         seg_en_q     <= seg_en_d;
      end
   end

   assign seg_data_o   = seg_data_q;
   assign seg_dp_o     = seg_dp_q;
   assign seg_an_o     = seg_an_q;
   assign seg_en_o     = seg_en_q;
   assign frame_done_o = frame_done_q;

endmodule
